display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment driver with a serial binary-to-BCD
// converter; a new value reaches the display only once fully converted.
module display_scan_ctrl #(
  parameter int DIV = 1349
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] data_in,
  input  logic        valid,
  output logic        ready,
  output logic [3:0]  anodes,
  output logic [6:0]  segments
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  localparam int TW = (DIV < 1) ? 1 : $clog2(DIV + 1);
  localparam logic [TW-1:0] TMAX = TW'(DIV);

  state_t        state;
  logic [13:0]   shreg;
  logic [15:0]   bcd;
  logic [15:0]   bcd_adj;
  logic [15:0]   bcd_nxt;
  logic [3:0]    iter;
  logic          ovf_pend;

  logic [15:0]   disp;
  logic          disp_ovf;
  logic [15:0]   disp_nxt;
  logic          ovf_nxt;

  logic [TW-1:0] tick;
  logic [TW-1:0] tick_nxt;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Double dabble: add 3 to any nibble >= 5 before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_nxt = {bcd_adj[14:0], shreg[13]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      shreg    <= '0;
      bcd      <= '0;
      iter     <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      disp_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid && ready) begin
            ready <= 1'b0;
            if (data_in > 14'd9999) begin
              ovf_pend <= 1'b1;
              state    <= COMMIT;
            end else begin
              ovf_pend <= 1'b0;
              shreg    <= data_in;
              bcd      <= '0;
              iter     <= '0;
              state    <= CONV;
            end
          end
        end
        CONV: begin
          bcd   <= bcd_nxt;
          shreg <= {shreg[12:0], 1'b0};
          iter  <= iter + 4'd1;
          if (iter == 4'd13)
            state <= COMMIT;
        end
        COMMIT: begin
          disp     <= bcd;
          disp_ovf <= ovf_pend;
          ready    <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Look ahead one edge so anodes and segments move together with the
  // index and with a freshly committed value.
  always_comb begin
    disp_nxt = (state == COMMIT) ? bcd : disp;
    ovf_nxt  = (state == COMMIT) ? ovf_pend : disp_ovf;
    tick_nxt = (tick == TMAX) ? '0 : tick + TW'(1);
    idx_nxt  = (tick == TMAX) ? idx + 2'd1 : idx;
    digit    = disp_nxt[4*idx_nxt +: 4];
    case (idx_nxt)
      2'd1:    blank = (disp_nxt[15:4] == 12'd0);
      2'd2:    blank = (disp_nxt[15:8] == 8'd0);
      2'd3:    blank = (disp_nxt[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    if (ovf_nxt)
      seg_nxt = 7'b0111111;
    else if (blank)
      seg_nxt = 7'b1111111;
    else
      seg_nxt = seg_of(digit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick     <= '0;
      idx      <= '0;
      anodes   <= 4'b1110;
      segments <= 7'b1000000;
    end else begin
      tick     <= tick_nxt;
      idx      <= idx_nxt;
      anodes   <= ~(4'b0001 << idx_nxt);
      segments <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a short scan period.
module tb_display_scan_ctrl;

  localparam int DIV = 3;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] data_in = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic [3:0]  anodes;
  logic [6:0]  segments;

  int total = 0;
  int bad = 0;

  display_scan_ctrl #(.DIV(DIV)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .valid(valid),
    .ready(ready),
    .anodes(anodes),
    .segments(segments)
  );

  always #5 clk = ~clk;

  task automatic wait_anode(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (anodes === want) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [3:0] an;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || anodes !== 4'b1110 || segments !== S0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b an=%b seg=%b want 1 1110 %b",
               ready, anodes, segments, S0);
    end
    reset = 1'b0;
    repeat (DIV) @(negedge clk);
    total++;
    if (anodes !== 4'b1110 || segments !== S0) begin
      bad++;
      $display("FAIL idx0_hold: an=%b seg=%b want 1110 %b",
               anodes, segments, S0);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      an = ~(4'b0001 << (k % 4));
      total++;
      if (anodes !== an || segments !== ((k % 4 == 0) ? S0 : SB)) begin
        bad++;
        $display("FAIL idx_step%0d: an=%b seg=%b want %b", k, anodes,
                 segments, an);
      end
      if (k < 4) repeat (DIV) @(negedge clk);
      else repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic test_1234;
    bit ok;
    logic [6:0] exp [4];
    wait_ready(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL r1234_wait: ready=%b want 1", ready); end
    valid = 1'b1;
    data_in = 14'd1234;
    @(negedge clk);
    valid = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (ready !== (k == 15)) begin
        bad++;
        $display("FAIL r1234_ready_T%0d: ready=%b want %b", k, ready, k == 15);
      end
      if (k < 15) begin
        total++;
        if (segments !== ((anodes == 4'b1110) ? S0 : SB)) begin
          bad++;
          $display("FAIL r1234_old_T%0d: an=%b seg=%b", k, anodes, segments);
        end
      end
    end
    exp[0] = S4; exp[1] = S3; exp[2] = S2; exp[3] = S1;
    for (int k = 3; k >= 0; k--) begin
      wait_anode(~(4'b0001 << k), ok);
      total++;
      if (!ok || segments !== exp[k]) begin
        bad++;
        $display("FAIL d1234_%0d: an=%b seg=%b want %b", k, anodes,
                 segments, exp[k]);
      end
    end
  endtask

  task automatic test_small;
    bit ok;
    logic [6:0] exp [4];
    logic [13:0] vals [2];
    vals[0] = 14'd7;
    vals[1] = 14'd1005;
    for (int v = 0; v < 2; v++) begin
      wait_ready(ok);
      valid = 1'b1;
      data_in = vals[v];
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      wait_ready(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL small%0d_commit: ready=%b want 1", v, ready); end
      if (v == 0) begin
        exp[0] = S7; exp[1] = SB; exp[2] = SB; exp[3] = SB;
      end else begin
        exp[0] = S5; exp[1] = S0; exp[2] = S0; exp[3] = S1;
      end
      for (int k = 0; k < 4; k++) begin
        wait_anode(~(4'b0001 << k), ok);
        total++;
        if (!ok || segments !== exp[k]) begin
          bad++;
          $display("FAIL small%0d_d%0d: an=%b seg=%b want %b", v, k,
                   anodes, segments, exp[k]);
        end
      end
    end
  endtask

  task automatic test_overflow;
    bit ok;
    wait_ready(ok);
    valid = 1'b1;
    data_in = 14'd12000;
    @(negedge clk);
    valid = 1'b0;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL ovf_T0: ready=%b want 0", ready); end
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || segments !== SD) begin
      bad++;
      $display("FAIL ovf_T1: ready=%b seg=%b want 1 %b", ready, segments, SD);
    end
    valid = 1'b1;
    data_in = 14'd16383;
    @(negedge clk);
    valid = 1'b0;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL ovf2_T0: ready=%b want 0", ready); end
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL ovf2_T1: ready=%b want 1", ready); end
    for (int k = 0; k < 4; k++) begin
      wait_anode(~(4'b0001 << k), ok);
      total++;
      if (!ok || segments !== SD) begin
        bad++;
        $display("FAIL ovf_d%0d: an=%b seg=%b want %b", k, anodes, segments, SD);
      end
    end
  endtask

  task automatic test_ignore_and_reset;
    bit ok;
    logic [6:0] exp [4];
    wait_ready(ok);
    valid = 1'b1;
    data_in = 14'd42;
    @(negedge clk);
    data_in = 14'd9000;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    valid = 1'b0;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL ign_ready: ready=%b want 1", ready); end
    exp[0] = S2; exp[1] = S4; exp[2] = SB; exp[3] = SB;
    for (int k = 0; k < 4; k++) begin
      wait_anode(~(4'b0001 << k), ok);
      total++;
      if (!ok || segments !== exp[k]) begin
        bad++;
        $display("FAIL ign_d%0d: an=%b seg=%b want %b", k, anodes,
                 segments, exp[k]);
      end
    end
    wait_ready(ok);
    valid = 1'b1;
    data_in = 14'd5678;
    @(negedge clk);
    valid = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (ready !== 1'b1 || anodes !== 4'b1110 || segments !== S0) begin
      bad++;
      $display("FAIL rst_mid: rdy=%b an=%b seg=%b want 1 1110 %b",
               ready, anodes, segments, S0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      total++;
      if (ready !== 1'b1 ||
          segments !== ((anodes == 4'b1110) ? S0 : SB)) begin
        bad++;
        $display("FAIL rst_after%0d: rdy=%b an=%b seg=%b", k, ready,
                 anodes, segments);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    wait_ready(ok);
    valid = 1'b1;
    data_in = 14'd9999;
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      total++;
      if (anodes !== 4'b1110 && anodes !== 4'b1101 &&
          anodes !== 4'b1011 && anodes !== 4'b0111) begin
        bad++;
        $display("FAIL b2b_onehot%0d: an=%b", k, anodes);
      end
      if (k == 15 || k == 31) begin
        total++;
        if (ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready%0d: ready=%b want 1", k, ready);
        end
      end
      if (k >= 15 && k <= 30) begin
        total++;
        if (segments !== S9) begin
          bad++;
          $display("FAIL b2b_9999_%0d: seg=%b want %b", k, segments, S9);
        end
      end
      if (k >= 31) begin
        total++;
        if (segments !== ((anodes == 4'b1110) ? S0 : SB)) begin
          bad++;
          $display("FAIL b2b_zero_%0d: an=%b seg=%b", k, anodes, segments);
        end
      end
      if (k == 15) begin
        valid = 1'b1;
        data_in = 14'd0;
      end else begin
        valid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_1234();
    test_small();
    test_overflow();
    test_ignore_and_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
